// File: rtl/pl_hazard_pkg.sv
// Shared encodings for the RV32I pipeline hazard controller: wait-FSM states,
// forwarding selects, the default load marker, and the forwarding-select helper.
package pl_hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned SRC_W = 2;

    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_ERR  = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [SRC_W-1:0] LOAD_SRC_DEF = 2'b01;

    // The younger producer in M wins over W; x0 is never a forwarding source.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic             we_m,
        input logic [REG_W-1:0] rd_m,
        input logic             we_w,
        input logic [REG_W-1:0] rd_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (we_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pl_mem_wait_fsm.sv
// Memory-wait sequencer: holds the pipeline while a data-memory access in M is
// outstanding and latches a sticky error if the handshake exceeds MEM_TIMEOUT cycles.
module pl_mem_wait_fsm
    import pl_hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_req,
    input  logic mem_ready,
    output logic mem_stall_c,
    output logic mem_err
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nx;

    // State, wait counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            count   <= '0;
            mem_err <= 1'b0;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            mem_err <= (state_nx == ST_ERR);
        end
    end

    // Ready in the same cycle as the request, or in any wait cycle, releases the stall at once.
    always_comb begin
        state_nx    = state;
        count_nx    = count;
        mem_stall_c = 1'b0;
        case (state)
            ST_RUN: begin
                mem_stall_c = mem_req && !mem_ready;
                if (mem_stall_c) begin
                    state_nx = ST_WAIT;
                    count_nx = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                mem_stall_c = !mem_ready;
                if (mem_ready) begin
                    state_nx = ST_RUN;
                    count_nx = '0;
                end else if (count == CNT_W'(MEM_TIMEOUT)) begin
                    state_nx = ST_ERR;
                end else begin
                    count_nx = count + CNT_W'(1);
                end
            end
            ST_ERR: begin
                mem_stall_c = 1'b1;
            end
            default: begin
                state_nx = ST_RUN;
                count_nx = '0;
            end
        endcase
    end

endmodule

// File: rtl/pl_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stalls, flushes,
// E-stage forwarding and memory-wait freeze. Define PL_HAZARD_PERF_EN for perf counters.
module pl_hazard_ctrl
    import pl_hazard_pkg::*;
#(
    parameter int unsigned      MEM_TIMEOUT = 16,
    parameter logic [SRC_W-1:0] LOAD_SRC    = LOAD_SRC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic [SRC_W-1:0] ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr
`ifdef PL_HAZARD_PERF_EN
    ,
    output logic [31:0]      StallCycles,
    output logic [31:0]      FlushCount
`endif
);

    logic mem_stall_c;
    logic lw_stall_c;

    pl_mem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (MemReqM),
        .mem_ready   (MemReadyM),
        .mem_stall_c (mem_stall_c),
        .mem_err     (MemErr)
    );

    // A load in E whose destination is read by D cannot be forwarded in time.
    assign lw_stall_c = (ResultSrcE == LOAD_SRC) && (RdE != '0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

    // Reset forces a bubble into F/D and D/E; a memory freeze suppresses flushes so a
    // branch held in E re-resolves once the access completes.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        StallW    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (rst_n) begin
            StallF    = lw_stall_c | mem_stall_c;
            StallD    = lw_stall_c | mem_stall_c;
            StallE    = mem_stall_c;
            StallM    = mem_stall_c;
            StallW    = mem_stall_c;
            FlushD    = PCSrcE & ~mem_stall_c;
            FlushE    = (lw_stall_c | PCSrcE) & ~mem_stall_c;
            ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
            ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
        end
    end

`ifdef PL_HAZARD_PERF_EN
    // Free-running wrap-around counters of front-end stall and E-flush cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (StallF) begin
                StallCycles <= StallCycles + 32'd1;
            end
            if (FlushE) begin
                FlushCount <= FlushCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Self-checking bench for pl_hazard_ctrl: directed vector table, multi-cycle memory
// sequences, and randomized traffic against a behavioural reference model.
module tb_pl_hazard_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemErr;
    logic [1:0]  ForwardAE, ForwardBE;
`ifdef PL_HAZARD_PERF_EN
    logic [31:0] StallCycles, FlushCount;
`endif

    always #5 clk = ~clk;

    pl_hazard_ctrl #(
        .MEM_TIMEOUT (TO),
        .LOAD_SRC    (2'b01)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .ResultSrcE (ResultSrcE),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .PCSrcE     (PCSrcE),
        .MemReqM    (MemReqM),
        .MemReadyM  (MemReadyM),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .StallW     (StallW),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .MemErr     (MemErr)
`ifdef PL_HAZARD_PERF_EN
        ,
        .StallCycles(StallCycles),
        .FlushCount (FlushCount)
`endif
    );

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rsrc;
        logic       wem, wew, pc, mreq, mrdy, rstn;
    } stim_t;

    typedef struct packed {
        logic       sfd, semw, fd, fe, err;
        logic [1:0] fa, fb;
    } exp_t;

    typedef struct packed {
        stim_t      s;
        logic       sfd, fd, fe;
        logic [1:0] fa, fb;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: an access is either idle, waiting for some number of cycles, or failed.
    bit          m_busy = 1'b0;
    int          m_waited = 0;
    bit          m_err = 1'b0;
    logic [31:0] m_sc = '0;
    logic [31:0] m_fc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input stim_t s);
        if (s.wem && s.rdm != 0 && s.rdm == rs) return 2'b10;
        if (s.wew && s.rdw != 0 && s.rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model_eval(input stim_t s);
        exp_t e;
        bit   ms, lw;
        if (m_err)       ms = 1'b1;
        else if (m_busy) ms = !s.mrdy;
        else             ms = s.mreq && !s.mrdy;
        lw = (s.rsrc == 2'b01) && (s.rde != 0) && (s.rde == s.rs1d || s.rde == s.rs2d);
        if (!s.rstn) begin
            e = '{sfd: 1'b0, semw: 1'b0, fd: 1'b1, fe: 1'b1, err: 1'b0, fa: 2'b00, fb: 2'b00};
        end else begin
            e.sfd  = lw | ms;
            e.semw = ms;
            e.fd   = s.pc & !ms;
            e.fe   = (lw | s.pc) & !ms;
            e.err  = m_err;
            e.fa   = fwd_ref(s.rs1e, s);
            e.fb   = fwd_ref(s.rs2e, s);
        end
        return e;
    endfunction

    task automatic model_advance(input stim_t s, input exp_t e);
        if (!s.rstn) begin
            m_busy = 1'b0; m_waited = 0; m_err = 1'b0; m_sc = '0; m_fc = '0;
        end else begin
            if (e.sfd) m_sc = m_sc + 1;
            if (e.fe)  m_fc = m_fc + 1;
            if (m_err) begin
            end else if (m_busy) begin
                if (s.mrdy)              m_busy = 1'b0;
                else if (m_waited == TO) m_err = 1'b1;
                else                     m_waited++;
            end else if (s.mreq && !s.mrdy) begin
                m_busy = 1'b1; m_waited = 1;
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, sample shortly after, advance the model.
    task automatic step(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst_n = s.rstn; Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
        RdE = s.rde; RdM = s.rdm; RdW = s.rdw; ResultSrcE = s.rsrc; RegWriteM = s.wem;
        RegWriteW = s.wew; PCSrcE = s.pc; MemReqM = s.mreq; MemReadyM = s.mrdy;
        #1;
        e = model_eval(s);
        chk("StallF", 32'(StallF), 32'(e.sfd));
        chk("StallD", 32'(StallD), 32'(e.sfd));
        chk("StallE", 32'(StallE), 32'(e.semw));
        chk("StallM", 32'(StallM), 32'(e.semw));
        chk("StallW", 32'(StallW), 32'(e.semw));
        chk("FlushD", 32'(FlushD), 32'(e.fd));
        chk("FlushE", 32'(FlushE), 32'(e.fe));
        chk("ForwardAE", 32'(ForwardAE), 32'(e.fa));
        chk("ForwardBE", 32'(ForwardBE), 32'(e.fb));
        chk("MemErr", 32'(MemErr), 32'(e.err));
`ifdef PL_HAZARD_PERF_EN
        chk("StallCycles", StallCycles, m_sc);
        chk("FlushCount", FlushCount, m_fc);
`endif
        model_advance(s, e);
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        s.rstn = 1'b1;
        return s;
    endfunction

    function automatic vec_t mkv(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                                 input logic [1:0] rsrc, input logic wem, wew, pc,
                                 input logic sfd, fd, fe, input logic [1:0] fa, fb);
        vec_t v;
        v.s = idle();
        v.s.rs1d = rs1d; v.s.rs2d = rs2d; v.s.rs1e = rs1e; v.s.rs2e = rs2e;
        v.s.rde = rde; v.s.rdm = rdm; v.s.rdw = rdw; v.s.rsrc = rsrc;
        v.s.wem = wem; v.s.wew = wew; v.s.pc = pc;
        v.sfd = sfd; v.fd = fd; v.fe = fe; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vt [13];
        stim_t s;

        vt[0]  = mkv(0, 0, 5, 0, 0, 5, 5, 2'b00, 1, 1, 0,  0, 0, 0, 2'b10, 2'b00);
        vt[1]  = mkv(0, 0, 5, 0, 0, 0, 5, 2'b00, 1, 1, 0,  0, 0, 0, 2'b01, 2'b00);
        vt[2]  = mkv(0, 0, 7, 7, 0, 7, 7, 2'b00, 0, 1, 0,  0, 0, 0, 2'b01, 2'b01);
        vt[3]  = mkv(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00);
        vt[4]  = mkv(0, 3, 0, 0, 3, 0, 0, 2'b01, 0, 0, 0,  1, 0, 1, 2'b00, 2'b00);
        vt[5]  = mkv(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        vt[6]  = mkv(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        vt[7]  = mkv(3, 0, 0, 0, 3, 0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        vt[8]  = mkv(4, 0, 0, 0, 4, 0, 0, 2'b10, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        vt[9]  = mkv(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1,  0, 1, 1, 2'b00, 2'b00);
        vt[10] = mkv(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        vt[11] = mkv(9, 3, 0, 0, 3, 0, 0, 2'b01, 0, 0, 1,  1, 1, 1, 2'b00, 2'b00);
        vt[12] = mkv(9, 0, 2, 9, 9, 2, 9, 2'b01, 1, 1, 0,  1, 0, 1, 2'b10, 2'b01);

        // Reset with forwarding-triggering inputs present.
        s = vt[0].s; s.rstn = 1'b0; s.mreq = 1'b1;
        step(s);
        chk("rst_ForwardAE", 32'(ForwardAE), 32'd0);
        chk("rst_FlushD", 32'(FlushD), 32'd1);
        chk("rst_FlushE", 32'(FlushE), 32'd1);
        chk("rst_StallF", 32'(StallF), 32'd0);
        step(idle());

        for (int i = 0; i < 13; i++) begin
            step(vt[i].s);
            chk($sformatf("tbl%0d_StallF", i), 32'(StallF), 32'(vt[i].sfd));
            chk($sformatf("tbl%0d_StallE", i), 32'(StallE), 32'd0);
            chk($sformatf("tbl%0d_FlushD", i), 32'(FlushD), 32'(vt[i].fd));
            chk($sformatf("tbl%0d_FlushE", i), 32'(FlushE), 32'(vt[i].fe));
            chk($sformatf("tbl%0d_FwdA", i), 32'(ForwardAE), 32'(vt[i].fa));
            chk($sformatf("tbl%0d_FwdB", i), 32'(ForwardBE), 32'(vt[i].fb));
        end

        // Memory wait: three not-ready cycles then ready; a branch inside the window is held.
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.mreq = 1'b1; s.mrdy = (i == 3); s.pc = (i == 1);
            step(s);
            chk($sformatf("memwait%0d_StallF", i), 32'(StallF), 32'(i != 3));
            chk($sformatf("memwait%0d_StallW", i), 32'(StallW), 32'(i != 3));
            if (i == 1) begin
                chk("memwait_branch_FlushD", 32'(FlushD), 32'd0);
                chk("memwait_branch_FlushE", 32'(FlushE), 32'd0);
            end
        end
        step(idle());

        // Timeout: one request cycle plus TO wait cycles, then sticky error.
        for (int i = 0; i < 6; i++) begin
            s = idle(); s.mreq = 1'b1;
            step(s);
            chk($sformatf("timeout%0d_MemErr", i), 32'(MemErr), 32'(i == 5));
        end
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.mrdy = 1'b1; s.pc = 1'b1;
            step(s);
            chk("err_sticky_MemErr", 32'(MemErr), 32'd1);
            chk("err_sticky_StallE", 32'(StallE), 32'd1);
            chk("err_sticky_FlushD", 32'(FlushD), 32'd0);
        end
        s = idle(); s.rstn = 1'b0;
        step(s);
        chk("err_rst_MemErr", 32'(MemErr), 32'd0);
        chk("err_rst_FlushE", 32'(FlushE), 32'd1);
        step(idle());
        chk("after_rst_StallF", 32'(StallF), 32'd0);

        // Reset while waiting leaves no residual stall.
        for (int i = 0; i < 2; i++) begin
            s = idle(); s.mreq = 1'b1;
            step(s);
        end
        s = idle(); s.mreq = 1'b1; s.rstn = 1'b0;
        step(s);
        chk("rst_wait_StallE", 32'(StallE), 32'd0);
        chk("rst_wait_FlushD", 32'(FlushD), 32'd1);
`ifdef PL_HAZARD_PERF_EN
        chk("rst_wait_StallCycles", StallCycles, 32'd0);
        chk("rst_wait_FlushCount", FlushCount, 32'd0);
`endif
        step(idle());
        chk("post_rst_wait_StallE", 32'(StallE), 32'd0);

        // Two load-use stalls and one branch after a fresh reset.
        s = idle(); s.rstn = 1'b0;
        step(s);
        step(vt[4].s);
        step(vt[4].s);
        step(vt[9].s);
        step(idle());
`ifdef PL_HAZARD_PERF_EN
        chk("perf_StallCycles", StallCycles, 32'd2);
        chk("perf_FlushCount", FlushCount, 32'd3);
`endif

        // Randomized traffic with small register numbers so hazards are frequent.
        for (int n = 0; n < 3000; n++) begin
            s.rs1d = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
            s.rs1e = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
            s.rde  = 5'($urandom_range(0, 3)); s.rdm  = 5'($urandom_range(0, 3));
            s.rdw  = 5'($urandom_range(0, 3)); s.rsrc = 2'($urandom_range(0, 3));
            s.wem  = 1'($urandom_range(0, 1)); s.wew  = 1'($urandom_range(0, 1));
            s.pc   = ($urandom_range(0, 4) == 0);
            s.mreq = ($urandom_range(0, 3) == 0);
            s.mrdy = 1'($urandom_range(0, 1));
            s.rstn = !((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0);
            step(s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
